mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 59 +++++
 rtl/mem_access_stage_load_align.sv | 35 +++
 rtl/mem_access_stage.sv | 125 ++++++++++++
 tb/tb_mem_access_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, WB select
// encodings, FSM states and the access legality helper.
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_t;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } mem_state_t;

    // True when funct3 names a real access of the given kind and the
    // low address bits satisfy its natural alignment.
    function automatic logic access_ok(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic legal;
        logic aligned;
        legal = 1'b0;
        if (is_load) begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lo[0];
            default: aligned = (lo == 2'b00);
        endcase
        return legal & aligned;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane extraction: picks the byte/half addressed by lane out of the
// returned word and sign- or zero-extends it according to funct3.
// Ports: rdata (memory word), lane (addr[1:0]), funct3, data (result).
module mem_access_stage_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import mem_access_stage_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over req/gnt/rvalid, aligns store lanes,
// extends load data, stalls upstream and bubbles MEM/WB while busy.
// Ports: ex_* from EX/MEM, dmem_* data-memory port, mem_* to MEM/WB,
// mem_stall_out holds the front end, mem_fault_out flags bad accesses.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result_in,
    input  logic [31:0] ex_store_data_in,
    input  logic [31:0] ex_pc_plus_4_in,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic        ex_reg_write_en_in,
    input  logic [1:0]  ex_mem_to_reg_in,
    input  logic        ex_mem_read_in,
    input  logic        ex_mem_write_in,
    input  logic [2:0]  ex_funct3_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_be_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] mem_alu_result_out,
    output logic [31:0] mem_load_data_out,
    output logic [31:0] mem_pc_plus_4_out,
    output logic [4:0]  mem_rd_addr_out,
    output logic        mem_reg_write_en_out,
    output logic [1:0]  mem_mem_to_reg_out,
    output logic        mem_stall_out,
    output logic        mem_fault_out
);
    import mem_access_stage_pkg::*;

    mem_state_t state;
    mem_state_t state_nxt;

    logic mem_op;
    logic ok;
    logic req;
    logic stall;
    logic fault;

    assign mem_op = ex_mem_read_in | ex_mem_write_in;
    assign ok     = access_ok(ex_mem_read_in, ex_funct3_in,
                              ex_alu_result_in[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // rvalid only matters in WAIT_RSP; in IDLE it belongs to no load.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    if (!ok) begin
                        fault = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (ex_mem_read_in) begin
                            stall = 1'b1;
                            if (dmem_gnt_in) state_nxt = S_WAIT_RSP;
                        end else begin
                            stall = ~dmem_gnt_in;
                        end
                    end
                end
            end
            S_WAIT_RSP: begin
                stall = ~dmem_rvalid_in;
                if (dmem_rvalid_in) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are combinational from inputs, so reset must mask them
    // directly rather than relying on the state register alone.
    assign dmem_req_out  = req & ~rst;
    assign dmem_we_out   = req & ~rst & ex_mem_write_in;
    assign mem_stall_out = stall & ~rst;
    assign mem_fault_out = fault & ~rst;
    assign dmem_addr_out = {ex_alu_result_in[31:2], 2'b00};

    always_comb begin
        dmem_be_out    = 4'b1111;
        dmem_wdata_out = ex_store_data_in;
        case (ex_funct3_in[1:0])
            2'b00: begin
                dmem_be_out    = 4'b0001 << ex_alu_result_in[1:0];
                dmem_wdata_out = {4{ex_store_data_in[7:0]}};
            end
            2'b01: begin
                dmem_be_out    = 4'b0011 << {ex_alu_result_in[1], 1'b0};
                dmem_wdata_out = {2{ex_store_data_in[15:0]}};
            end
            default: begin
                dmem_be_out    = 4'b1111;
                dmem_wdata_out = ex_store_data_in;
            end
        endcase
    end

    mem_access_stage_load_align u_load_align (
        .rdata  (dmem_rdata_in),
        .lane   (ex_alu_result_in[1:0]),
        .funct3 (ex_funct3_in),
        .data   (mem_load_data_out)
    );

    assign mem_alu_result_out   = ex_alu_result_in;
    assign mem_pc_plus_4_out    = ex_pc_plus_4_in;
    assign mem_rd_addr_out      = ex_rd_addr_in;
    assign mem_mem_to_reg_out   = ex_mem_to_reg_in;
    assign mem_reg_write_en_out = ex_reg_write_en_in & ~stall
                                  & ~fault & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random
// loads/stores/no-ops against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_alu_result_in;
    logic [31:0] ex_store_data_in;
    logic [31:0] ex_pc_plus_4_in;
    logic [4:0]  ex_rd_addr_in;
    logic        ex_reg_write_en_in;
    logic [1:0]  ex_mem_to_reg_in;
    logic        ex_mem_read_in;
    logic        ex_mem_write_in;
    logic [2:0]  ex_funct3_in;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_be_out;
    logic        dmem_gnt_in;
    logic        dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;
    logic [31:0] mem_alu_result_out;
    logic [31:0] mem_load_data_out;
    logic [31:0] mem_pc_plus_4_out;
    logic [4:0]  mem_rd_addr_out;
    logic        mem_reg_write_en_out;
    logic [1:0]  mem_mem_to_reg_out;
    logic        mem_stall_out;
    logic        mem_fault_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_alu_result_in     (ex_alu_result_in),
        .ex_store_data_in     (ex_store_data_in),
        .ex_pc_plus_4_in      (ex_pc_plus_4_in),
        .ex_rd_addr_in        (ex_rd_addr_in),
        .ex_reg_write_en_in   (ex_reg_write_en_in),
        .ex_mem_to_reg_in     (ex_mem_to_reg_in),
        .ex_mem_read_in       (ex_mem_read_in),
        .ex_mem_write_in      (ex_mem_write_in),
        .ex_funct3_in         (ex_funct3_in),
        .dmem_req_out         (dmem_req_out),
        .dmem_we_out          (dmem_we_out),
        .dmem_addr_out        (dmem_addr_out),
        .dmem_wdata_out       (dmem_wdata_out),
        .dmem_be_out          (dmem_be_out),
        .dmem_gnt_in          (dmem_gnt_in),
        .dmem_rvalid_in       (dmem_rvalid_in),
        .dmem_rdata_in        (dmem_rdata_in),
        .mem_alu_result_out   (mem_alu_result_out),
        .mem_load_data_out    (mem_load_data_out),
        .mem_pc_plus_4_out    (mem_pc_plus_4_out),
        .mem_rd_addr_out      (mem_rd_addr_out),
        .mem_reg_write_en_out (mem_reg_write_en_out),
        .mem_mem_to_reg_out   (mem_mem_to_reg_out),
        .mem_stall_out        (mem_stall_out),
        .mem_fault_out        (mem_fault_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input bit [2:0] f3);
        int s;
        s = 1 << f3[1:0];
        return s;
    endfunction

    function automatic bit m_legal(input bit ld, input bit [2:0] f3,
                                   input bit [31:0] a);
        int s;
        if (ld) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end else begin
            if (f3 > 3'd2) return 1'b0;
        end
        s = acc_size(f3);
        return (a % s) == 0;
    endfunction

    function automatic bit [3:0] m_be(input bit [2:0] f3,
                                      input bit [31:0] a);
        int s, off;
        bit [3:0] r;
        s   = acc_size(f3);
        off = a % 4;
        r   = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + s) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3,
                                          input bit [31:0] d);
        case (acc_size(f3))
            1:       return (d % 256) * 32'h0101_0101;
            2:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3,
                                         input bit [31:0] a,
                                         input bit [31:0] rd);
        longint v, span;
        int s;
        s = acc_size(f3);
        if (s == 4) return rd;
        span = longint'(1) << (8 * s);
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (f3 < 3'd4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- one instruction through MEM ----------------
    task automatic do_op(input bit rd, input bit wr, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] d,
                         input bit rwe, input int gdly, input int rdly,
                         input bit [31:0] rdv);
        bit [31:0] pc;
        bit [4:0]  rda;
        pc  = $urandom;
        rda = 5'($urandom);
        ex_alu_result_in   = a;
        ex_store_data_in   = d;
        ex_pc_plus_4_in    = pc;
        ex_rd_addr_in      = rda;
        ex_reg_write_en_in = rwe;
        ex_mem_to_reg_in   = rd ? 2'b01 : 2'($urandom_range(0, 2));
        ex_mem_read_in     = rd;
        ex_mem_write_in    = wr;
        ex_funct3_in       = f3;
        if (!(rd | wr)) begin
            dmem_gnt_in    = 1'($urandom);
            dmem_rvalid_in = 1'($urandom);
            @(negedge clk);
            chk("nop_req", 32'(dmem_req_out), 0);
            chk("nop_stall", 32'(mem_stall_out), 0);
            chk("nop_we", 32'(mem_reg_write_en_out), 32'(rwe));
            chk("nop_alu", mem_alu_result_out, a);
            chk("nop_pc", mem_pc_plus_4_out, pc);
            chk("nop_rd", 32'(mem_rd_addr_out), 32'(rda));
            @(posedge clk); #1;
            return;
        end
        if (!m_legal(rd, f3, a)) begin
            dmem_gnt_in    = 1'($urandom);
            dmem_rvalid_in = 1'($urandom);
            @(negedge clk);
            chk("flt_fault", 32'(mem_fault_out), 1);
            chk("flt_req", 32'(dmem_req_out), 0);
            chk("flt_stall", 32'(mem_stall_out), 0);
            chk("flt_we", 32'(mem_reg_write_en_out), 0);
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= gdly; k++) begin
            dmem_gnt_in    = (k == gdly);
            dmem_rvalid_in = 1'($urandom);
            dmem_rdata_in  = $urandom;
            @(negedge clk);
            chk("rq_req", 32'(dmem_req_out), 1);
            chk("rq_dwe", 32'(dmem_we_out), 32'(wr));
            chk("rq_addr", dmem_addr_out, {a[31:2], 2'b00});
            chk("rq_fault", 32'(mem_fault_out), 0);
            if (wr) begin
                chk("st_be", 32'(dmem_be_out), 32'(m_be(f3, a)));
                chk("st_wdata", dmem_wdata_out, m_wdata(f3, d));
                chk("st_stall", 32'(mem_stall_out), 32'(k < gdly));
                chk("st_we", 32'(mem_reg_write_en_out),
                    (k == gdly) ? 32'(rwe) : 0);
            end else begin
                chk("ld_stall", 32'(mem_stall_out), 1);
                chk("ld_we", 32'(mem_reg_write_en_out), 0);
            end
            @(posedge clk); #1;
        end
        dmem_gnt_in = 1'b0;
        if (rd) begin
            for (int w = 0; w <= rdly; w++) begin
                dmem_rvalid_in = (w == rdly);
                dmem_rdata_in  = (w == rdly) ? rdv : $urandom;
                @(negedge clk);
                chk("rs_req", 32'(dmem_req_out), 0);
                chk("rs_stall", 32'(mem_stall_out), 32'(w < rdly));
                chk("rs_we", 32'(mem_reg_write_en_out),
                    (w == rdly) ? 32'(rwe) : 0);
                if (w == rdly)
                    chk("rs_data", mem_load_data_out, m_load(f3, a, rdv));
                @(posedge clk); #1;
            end
        end
        dmem_rvalid_in = 1'b0;
    endtask

    initial begin
        bit        rd, wr;
        bit [2:0]  f3;
        bit [31:0] a;
        int        kind;

        rst                = 1'b1;
        ex_alu_result_in   = 32'h100;
        ex_store_data_in   = '0;
        ex_pc_plus_4_in    = '0;
        ex_rd_addr_in      = 5'd1;
        ex_reg_write_en_in = 1'b1;
        ex_mem_to_reg_in   = 2'b01;
        ex_mem_read_in     = 1'b1;
        ex_mem_write_in    = 1'b0;
        ex_funct3_in       = 3'b010;
        dmem_gnt_in        = 1'b1;
        dmem_rvalid_in     = 1'b1;
        dmem_rdata_in      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req_out), 0);
        chk("rst_stall", 32'(mem_stall_out), 0);
        chk("rst_we", 32'(mem_reg_write_en_out), 0);
        chk("rst_fault", 32'(mem_fault_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_gnt_in    = 1'b0;
        dmem_rvalid_in = 1'b0;

        // Directed cases.
        do_op(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_op(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 0, 0);
        do_op(0, 1, 3'b001, 32'h302, 32'h1234_5678, 0, 2, 0, 0);
        do_op(1, 0, 3'b000, 32'h101, 0, 1, 0, 1, 32'h0000_80FF);
        do_op(1, 0, 3'b100, 32'h101, 0, 1, 0, 1, 32'h0000_80FF);
        do_op(1, 0, 3'b010, 32'h40, 0, 1, 3, 0, 32'hCAFE_F00D);
        do_op(1, 0, 3'b001, 32'h103, 0, 1, 0, 0, 0);
        do_op(1, 0, 3'b011, 32'h104, 0, 1, 0, 0, 0);
        do_op(1, 0, 3'b101, 32'h106, 0, 1, 0, 2, 32'h8001_7FFF);
        do_op(0, 1, 3'b010, 32'h106, 32'h1, 1, 0, 0, 0);
        do_op(0, 0, 3'b000, 32'h55, 0, 1, 0, 0, 0);

        // Reset while a load waits for its response.
        ex_alu_result_in = 32'h80;
        ex_funct3_in     = 3'b010;
        ex_mem_read_in   = 1'b1;
        ex_mem_write_in  = 1'b0;
        ex_reg_write_en_in = 1'b1;
        dmem_gnt_in      = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_in = 1'b0;
        @(negedge clk);
        chk("wr_stall", 32'(mem_stall_out), 1);
        #1 rst = 1'b1;
        #1;
        chk("wr_rst_stall", 32'(mem_stall_out), 0);
        chk("wr_rst_req", 32'(dmem_req_out), 0);
        chk("wr_rst_we", 32'(mem_reg_write_en_out), 0);
        @(posedge clk); #1;
        rst            = 1'b0;
        ex_mem_read_in = 1'b0;
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'h1111_2222;
        @(negedge clk);
        chk("late_stall", 32'(mem_stall_out), 0);
        chk("late_req", 32'(dmem_req_out), 0);
        chk("late_we", 32'(mem_reg_write_en_out), 1);
        @(posedge clk); #1;
        dmem_rvalid_in = 1'b0;
        do_op(1, 0, 3'b010, 32'h84, 0, 1, 1, 1, 32'h3333_4444);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            rd   = (kind == 1 || kind == 2);
            wr   = (kind == 3 || kind == 4);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom)
                 : (wr ? 3'($urandom_range(0, 2))
                       : 3'({$urandom_range(0, 1), 2'b00})
                         | 3'($urandom_range(0, 1)));
            if (rd && $urandom_range(0, 3) == 0) f3 = 3'b010;
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'(acc_size(f3))) - 1);
            do_op(rd, wr, f3, a, $urandom, 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
